// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side read ports and the downstream memory read channel.
//
// Handshake: a port request (xx_RDEN with xx_RADDR) is taken at a rising edge
// where xx_RDEN=1 and MEM_WAIT=0. While MEM_WAIT=1 the requester holds
// xx_RDEN/xx_RADDR steady and the arbiter ignores them. Responses are
// single-cycle xx_RVALID pulses with xx_RDATA. Downstream, MEM_RDEN is a
// one-cycle strobe; MEM_RVALID/MEM_RDATA may return any number of cycles
// later (at least one).
interface mem_arbiter_if;
  logic        INST_RDEN;
  logic [31:0] INST_RADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN;
  logic [31:0] DATA_RADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        MEM_WAIT;
  logic        MEM_RDEN;
  logic [31:0] MEM_RADDR;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;

  // Arbiter side.
  modport slave (
    input  INST_RDEN, INST_RADDR, DATA_RDEN, DATA_RADDR, MEM_RVALID, MEM_RDATA,
    output INST_RVALID, INST_RDATA, DATA_RVALID, DATA_RDATA,
           MEM_WAIT, MEM_RDEN, MEM_RADDR
  );

  // Core plus memory side.
  modport master (
    output INST_RDEN, INST_RADDR, DATA_RDEN, DATA_RADDR, MEM_RVALID, MEM_RDATA,
    input  INST_RVALID, INST_RDATA, DATA_RVALID, DATA_RDATA,
           MEM_WAIT, MEM_RDEN, MEM_RADDR
  );
endinterface

// File: rtl/mem_arbiter.sv
// Read-port arbiter: instruction-fetch and data-read ports share one memory
// read channel. One single-entry slot per port, one transaction in flight,
// responses routed back to the owner of the current grant.
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1  // 1: data always wins a tie, 0: alternate
) (
  input  logic             CLK,
  input  logic             RST,
  mem_arbiter_if.slave     bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_inst_pend;
  logic        r_data_pend;
  logic [31:0] r_inst_addr;
  logic [31:0] r_data_addr;
  logic        r_owner_data;  // owner of the current grant: 1 = data port
  logic        r_last_data;   // port granted most recently: 1 = data port
  logic [31:0] r_mem_raddr;
  logic        r_inst_rvalid;
  logic        r_data_rvalid;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  logic        w_wait;
  logic        w_grant;
  logic        w_grant_data;
  logic        w_inst_acc;
  logic        w_data_acc;
  logic        w_done;

  // Stall is decoded purely from flops so the core sees no input-to-output path.
  assign w_wait     = r_inst_pend | r_data_pend | (r_state != S_IDLE);
  assign w_inst_acc = bus.INST_RDEN & ~w_wait;
  assign w_data_acc = bus.DATA_RDEN & ~w_wait;
  assign w_grant    = (r_state == S_IDLE) && (w_state_nxt == S_ISSUE);
  assign w_done     = (r_state == S_WAIT) && bus.MEM_RVALID;

  assign bus.MEM_WAIT    = w_wait;
  assign bus.MEM_RDEN    = (r_state == S_ISSUE);
  assign bus.MEM_RADDR   = r_mem_raddr;
  assign bus.INST_RVALID = r_inst_rvalid;
  assign bus.INST_RDATA  = r_inst_rdata;
  assign bus.DATA_RVALID = r_data_rvalid;
  assign bus.DATA_RDATA  = r_data_rdata;
  assign o_dbg_state     = r_state;

  // Next-state and grant selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_inst_pend || r_data_pend) begin
          w_state_nxt = S_ISSUE;
          if (r_inst_pend && r_data_pend) begin
            w_grant_data = DATA_FIRST ? 1'b1 : ~r_last_data;
          end else begin
            w_grant_data = r_data_pend;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.MEM_RVALID) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request slots: capture on acceptance, release when the owner's response lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inst_pend <= 1'b0;
      r_data_pend <= 1'b0;
      r_inst_addr <= 32'd0;
      r_data_addr <= 32'd0;
    end else begin
      if (w_inst_acc) begin
        r_inst_pend <= 1'b1;
        r_inst_addr <= bus.INST_RADDR;
      end else if (w_done && !r_owner_data) begin
        r_inst_pend <= 1'b0;
      end
      if (w_data_acc) begin
        r_data_pend <= 1'b1;
        r_data_addr <= bus.DATA_RADDR;
      end else if (w_done && r_owner_data) begin
        r_data_pend <= 1'b0;
      end
    end
  end

  // Grant bookkeeping and downstream address, latched when a grant is made.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner_data <= 1'b0;
      r_last_data  <= 1'b0;
      r_mem_raddr  <= 32'd0;
    end else if (w_grant) begin
      r_owner_data <= w_grant_data;
      r_last_data  <= w_grant_data;
      r_mem_raddr  <= w_grant_data ? r_data_addr : r_inst_addr;
    end
  end

  // Response routing: one-cycle valid pulse to the owner, data held until next response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inst_rvalid <= 1'b0;
      r_data_rvalid <= 1'b0;
      r_inst_rdata  <= 32'd0;
      r_data_rdata  <= 32'd0;
    end else begin
      r_inst_rvalid <= w_done & ~r_owner_data;
      r_data_rvalid <= w_done &  r_owner_data;
      if (w_done && !r_owner_data) r_inst_rdata <= bus.MEM_RDATA;
      if (w_done &&  r_owner_data) r_data_rdata <= bus.MEM_RDATA;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance per priority mode, both driven by the
// same core stimulus, each with its own memory responder and reference model.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic        core_inst_rden  = 1'b0;
  logic [31:0] core_inst_raddr = 32'd0;
  logic        core_data_rden  = 1'b0;
  logic [31:0] core_data_raddr = 32'd0;

  int fixed_lat   = 1;     // 0 = use lat_tab
  bit spurious_en = 1'b0;
  int lat_tab[256];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUTs, responders, models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit    DF = (g == 0);
    localparam string PX = (g == 0) ? "df1" : "df0";

    mem_arbiter_if bus();
    logic [1:0] dbg_state;

    mem_arbiter #(.DATA_FIRST(DF)) u_dut (
      .CLK         (clk),
      .RST         (rst),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
    );

    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = 32'd0;
    assign bus.INST_RDEN  = core_inst_rden;
    assign bus.INST_RADDR = core_inst_raddr;
    assign bus.DATA_RDEN  = core_data_rden;
    assign bus.DATA_RADDR = core_data_raddr;
    assign bus.MEM_RVALID = rsp_valid;
    assign bus.MEM_RDATA  = rsp_data;

    // Memory responder: answers each strobe after a latency >= 1; ignores reset.
    bit          owe = 1'b0;
    int          cnt = 0;
    int          txn = 0;
    logic [31:0] owe_addr = 32'd0;
    always @(posedge clk) begin
      #1;
      rsp_valid = 1'b0;
      if (owe) begin
        cnt--;
        if (cnt <= 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_fn(owe_addr);
          owe       = 1'b0;
        end
      end else if (spurious_en && !bus.MEM_RDEN && $urandom_range(0, 7) == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = $urandom;
      end
      if (bus.MEM_RDEN) begin
        owe      = 1'b1;
        owe_addr = bus.MEM_RADDR;
        cnt      = (fixed_lat > 0) ? fixed_lat : lat_tab[txn % 256];
        txn++;
      end
    end

    // Log of issued addresses, in order.
    logic [31:0] iss_log[64];
    int          iss_n = 0;
    always @(negedge clk) begin
      if (bus.MEM_RDEN === 1'b1) begin
        iss_log[iss_n % 64] = bus.MEM_RADDR;
        iss_n++;
      end
    end

    // Reference model: transaction queue of accepted requests in service order.
    int          m_out = 0;          // accepted, response not yet delivered
    logic [32:0] m_q[$];             // {is_data, addr}
    int          m_rden_cyc = -1;    // cycle in which the next strobe is due
    bit          m_infl = 1'b0;
    logic [32:0] m_cur = 33'd0;
    int          m_due = -1;         // cycle of the next response pulse
    bit          m_due_data = 1'b0;
    logic [31:0] m_due_val = 32'd0;
    logic [31:0] m_inst_d = 32'd0;
    logic [31:0] m_data_d = 32'd0;
    bit          m_last_data = 1'b0;
    bit          m_live = 1'b0;
    bit          rst_prev = 1'b0;

    always @(negedge clk) begin
      bit wait_n;
      bit due_now;
      bit first_data;
      wait_n  = (m_out > 0);
      due_now = (m_due == cyc);
      if (m_live) begin
        check_eq({PX, "_wait"}, bus.MEM_WAIT, wait_n);
        check_eq({PX, "_rden"}, bus.MEM_RDEN, m_rden_cyc == cyc);
        if (m_rden_cyc == cyc && m_q.size() > 0)
          check_eq({PX, "_raddr"}, bus.MEM_RADDR, m_q[0][31:0]);
        check_eq({PX, "_inst_rvalid"}, bus.INST_RVALID, due_now && !m_due_data);
        check_eq({PX, "_data_rvalid"}, bus.DATA_RVALID, due_now && m_due_data);
        if (due_now) begin
          if (m_due_data) m_data_d = m_due_val;
          else            m_inst_d = m_due_val;
        end
        check_eq({PX, "_inst_rdata"}, bus.INST_RDATA, m_inst_d);
        check_eq({PX, "_data_rdata"}, bus.DATA_RDATA, m_data_d);
        if (rst_prev) check_eq({PX, "_raddr_rst"}, bus.MEM_RADDR, 32'd0);
      end
      if (rst) begin
        m_live = 1'b1;
        rst_prev = 1'b1;
        m_out = 0;
        m_q.delete();
        m_rden_cyc = -1;
        m_infl = 1'b0;
        m_due = -1;
        m_inst_d = 32'd0;
        m_data_d = 32'd0;
        m_last_data = 1'b0;
      end else begin
        rst_prev = 1'b0;
        if (m_infl && bus.MEM_RVALID) begin
          m_due      = cyc + 1;
          m_due_data = m_cur[32];
          m_due_val  = mem_fn(m_cur[31:0]);
          m_infl     = 1'b0;
          m_out--;
          if (m_q.size() > 0) m_rden_cyc = cyc + 2;
        end
        if (m_rden_cyc == cyc && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_infl = 1'b1;
          m_rden_cyc = -1;
        end
        if (!wait_n && (core_inst_rden || core_data_rden)) begin
          if (core_inst_rden && core_data_rden)
            first_data = DF ? 1'b1 : !m_last_data;
          else
            first_data = core_data_rden;
          m_q.push_back({first_data, first_data ? core_data_raddr : core_inst_raddr});
          m_last_data = first_data;
          m_out = 1;
          if (core_inst_rden && core_data_rden) begin
            m_q.push_back({!first_data, first_data ? core_inst_raddr : core_data_raddr});
            m_last_data = !first_data;
            m_out = 2;
          end
          m_rden_cyc = cyc + 2;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request and hold it until the arbiter takes it.
  task automatic send(input bit di, input bit dd, input logic [31:0] ia, input logic [31:0] da);
    int guard;
    @(posedge clk); #1;
    core_inst_rden  = di;
    core_inst_raddr = ia;
    core_data_rden  = dd;
    core_data_raddr = da;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (g_inst[0].bus.MEM_WAIT !== 1'b0 && guard < 300);
    check_eq("accept_in_time", guard < 300, 1'b1);
    @(posedge clk); #1;
    core_inst_rden = 1'b0;
    core_data_rden = 1'b0;
  endtask

  task automatic wait_quiet();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((g_inst[0].m_out > 0 || g_inst[1].m_out > 0 ||
                g_inst[0].owe || g_inst[1].owe) && guard < 500);
    check_eq("quiet_in_time", guard < 500, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n0;
    int          n1;
    int          guard;
    logic [31:0] ia;
    logic [31:0] da;
    bit          di;
    bit          dd;

    for (int i = 0; i < 256; i++) lat_tab[i] = $urandom_range(1, 6);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single instruction fetch.
    send(1'b1, 1'b0, 32'h100, 32'h0);
    wait_quiet();
    check_eq("single_inst_rdata", g_inst[0].bus.INST_RDATA, 32'hDEADBEEF);

    // Simultaneous requests: data first in both modes at this point.
    n0 = g_inst[0].iss_n;
    send(1'b1, 1'b1, 32'h200, 32'h8000);
    wait_quiet();
    check_eq("simul_count", g_inst[0].iss_n - n0, 2);
    check_eq("simul_first", g_inst[0].iss_log[n0 % 64], 32'h8000);
    check_eq("simul_second", g_inst[0].iss_log[(n0 + 1) % 64], 32'h200);

    // Round-robin: three rounds, each data then inst.
    for (int r = 0; r < 3; r++) begin
      ia = {$urandom_range(0, 65535), 16'h0} | 32'h10;
      da = {$urandom_range(0, 65535), 16'h0} | 32'h20;
      n1 = g_inst[1].iss_n;
      send(1'b1, 1'b1, ia, da);
      wait_quiet();
      check_eq("rr_count", g_inst[1].iss_n - n1, 2);
      check_eq("rr_first_data", g_inst[1].iss_log[n1 % 64], da);
      check_eq("rr_second_inst", g_inst[1].iss_log[(n1 + 1) % 64], ia);
    end

    // Variable latency.
    fixed_lat = 5;
    n0 = g_inst[0].iss_n;
    send(1'b0, 1'b1, 32'h0000_4440, 32'h0000_7770);
    wait_quiet();
    check_eq("varlat_one_strobe", g_inst[0].iss_n - n0, 1);
    check_eq("varlat_data", g_inst[0].bus.DATA_RDATA, mem_fn(32'h0000_7770));

    // Reset while waiting on memory; the late response must be dropped.
    fixed_lat = 8;
    send(1'b1, 1'b0, 32'h300, 32'h0);
    guard = 0;
    while (!g_inst[0].owe && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst_reached_wait", g_inst[0].owe, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    guard = 0;
    while (g_inst[0].owe && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_no_late_rdata", g_inst[0].bus.INST_RDATA, 32'd0);
    check_eq("rst_wait_low", g_inst[0].bus.MEM_WAIT, 1'b0);
    fixed_lat = 1;
    send(1'b1, 1'b0, 32'h304, 32'h0);
    wait_quiet();
    check_eq("after_rst_rdata", g_inst[0].bus.INST_RDATA, mem_fn(32'h304));

    // Held request through a stall window, with spurious responses in idle.
    spurious_en = 1'b1;
    fixed_lat = 4;
    n0 = g_inst[0].iss_n;
    send(1'b0, 1'b1, 32'h0, 32'h400);
    send(1'b1, 1'b0, 32'h500, 32'h0);
    wait_quiet();
    check_eq("held_count", g_inst[0].iss_n - n0, 2);
    check_eq("held_addr", g_inst[0].iss_log[(n0 + 1) % 64], 32'h500);
    repeat (30) @(negedge clk);

    // Randomized traffic with variable latency.
    fixed_lat = 0;
    for (int k = 0; k < 300; k++) begin
      di = $urandom_range(0, 1);
      dd = $urandom_range(0, 1);
      if (!di && !dd) dd = 1'b1;
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom & 32'hFFFF_FFFC;
      send(di, dd, ia, da);
      if ($urandom_range(0, 3) == 0) wait_quiet();
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_quiet();
    spurious_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Read-port arbiter between the core's instruction-fetch port and its data-read port, sharing one downstream memory read channel. Sits between `core` and the memory subsystem. Accepts at most one request per port into a single-entry slot, issues one memory transaction at a time, and routes each response back to its requester. Drives `MEM_WAIT` to hold the core while any work is pending.

## Interface
Parameters:
- `DATA_FIRST`, default 1. 1 = fixed priority, data over instruction. 0 = round-robin when both ports are pending.

Ports:
- `CLK` in 1: clock. One clock domain.
- `RST` in 1: synchronous, active-high reset.
- `INST_RDEN` in 1: instruction read request.
- `INST_RADDR` in 32: instruction address.
- `INST_RVALID` out 1: instruction response valid, one-cycle pulse.
- `INST_RDATA` out 32: instruction response data.
- `DATA_RDEN` in 1: data read request.
- `DATA_RADDR` in 32: data address.
- `DATA_RVALID` out 1: data response valid, one-cycle pulse.
- `DATA_RDATA` out 32: data response data.
- `MEM_WAIT` out 1: stall to core.
- `MEM_RDEN` out 1: downstream read strobe, one-cycle pulse.
- `MEM_RADDR` out 32: downstream address.
- `MEM_RVALID` in 1: downstream response valid.
- `MEM_RDATA` in 32: downstream response data.

## Operation
- **Slots:** one per port, each holding a pending bit and a 32-bit address.
  - A port's request is accepted at a clock edge where its `xx_RDEN`=1 and `MEM_WAIT`=0. Both ports may be accepted at the same edge.
  - While `MEM_WAIT`=1, `xx_RDEN` and `xx_RADDR` are ignored. The core holds them, so no request is captured twice.
- **MEM_WAIT** = `inst_pend | data_pend | (state != IDLE)`. It is decoded from flops only, with no input-to-output combinational path.
- **FSM:**
  - **IDLE:** if any slot is pending, grant one, latch the grant owner, go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** `MEM_RDEN`=1 and `MEM_RADDR`=granted slot address, for exactly one cycle. Then go to WAIT.
  - **WAIT:** hold until `MEM_RVALID`=1. On that edge: owner's `xx_RVALID`<=1, `xx_RDATA`<=`MEM_RDATA`, clear the owner's slot, go to IDLE.
- **Grant rules:**
  - Only one slot pending: grant it.
  - Both pending with `DATA_FIRST`=1: grant data.
  - Both pending with `DATA_FIRST`=0: grant the port not granted last. The last-grant flag resets to "inst", so data wins the first tie.
- **Response routing:**
  - `MEM_RVALID` outside WAIT is ignored; no slot is cleared and no `RVALID` is produced.
  - `xx_RDATA` holds its last value until the next response to that port.
  - Only one transaction is outstanding at any time.
- **Reset:** all slots cleared, FSM to IDLE, last-grant flag = inst. An in-flight transaction is abandoned and its late `MEM_RVALID` is ignored.

## Timing
- **Reset values:** `MEM_RDEN`=0, `MEM_RADDR`=0, `INST_RVALID`=0, `INST_RDATA`=0, `DATA_RVALID`=0, `DATA_RDATA`=0, `MEM_WAIT`=0. `MEM_WAIT` is 0 in the first cycle after reset is released.
- **Minimum single-request sequence** (request accepted at edge E0; downstream responds the cycle after `MEM_RDEN`):
  - Cycle E0+1: IDLE, grant; `MEM_WAIT`=1.
  - Cycle E0+2: ISSUE; `MEM_RDEN`=1.
  - Cycle E0+3: WAIT; `MEM_RVALID`=1.
  - Cycle E0+4: `xx_RVALID`=1 with data. `MEM_WAIT`=0 if the other slot is empty.
- **Latency:** 4 cycles from acceptance to `RVALID` at minimum, plus the downstream latency beyond 1 cycle.
- **Two simultaneous requests:** the second grant happens in the cycle its partner's `RVALID` is high. Its `RVALID` follows 3 cycles plus downstream latency later.
- **Downstream contract:** `MEM_RVALID` must arrive at least 1 cycle after `MEM_RDEN`. Downstream latency is unbounded; the arbiter waits in WAIT indefinitely.
- **Output pulses:** `xx_RVALID` is high for exactly one cycle per accepted request. `INST_RVALID` and `DATA_RVALID` are never high in the same cycle.

## Test plan
- **Single instruction fetch:** `INST_RDEN`=1, `INST_RADDR`=0x100 at edge E0; memory returns 0xDEADBEEF one cycle after `MEM_RDEN` -> `MEM_RDEN` pulse with `MEM_RADDR`=0x100 in cycle E0+2; `INST_RVALID`=1 with 0xDEADBEEF in cycle E0+4; `MEM_WAIT` high over E0+1..E0+3.
- **Simultaneous requests, `DATA_FIRST`=1:** inst 0x200 and data 0x8000 accepted at the same edge -> `MEM_RADDR` order 0x8000 then 0x200; `DATA_RVALID` precedes `INST_RVALID`; `MEM_WAIT` drops only after the second `RVALID`.
- **Round-robin, `DATA_FIRST`=0:** three back-to-back rounds with both ports requesting -> grant order data, inst, data, inst, data, inst.
- **Variable latency:** `MEM_RVALID` delayed 5 cycles -> state stays WAIT; exactly one `RVALID`; data matches; no second `MEM_RDEN` is issued meanwhile.
- **Reset mid-WAIT:** assert `RST` during WAIT, then deliver `MEM_RVALID` after release -> no `RVALID` pulse; all outputs 0; a new request completes normally.
- **Held request under stall:** keep `INST_RDEN`=1 with a constant address through a `MEM_WAIT` window -> exactly one `MEM_RDEN` for that address. A spurious `MEM_RVALID` in IDLE produces nothing.
